// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the math blocks (ln / exp LUT pipelines).
// Holds the common widths, constants and small payload types.
package fpga_cfg_pkg;

    localparam int FP_WIDTH    = 32;
    localparam int FP_QFRAC    = 16;
    localparam int FP_LUT_BITS = 10;

    // log2(e) in Q16.16, used to turn exp(x) into 2^(x*log2e)
    localparam logic [31:0] FP_LOG2E = 32'h00017154;
    localparam string FP_EXP_LUT_FILE = "gen/exp2_lut_q16.hex";

    typedef struct packed {
        logic pos;
        logic under;
    } exp_flags_t;

endpackage

// File: rtl/fx_exp2_rom.sv
// Dual-read synchronous ROM holding T[j] = round(2^(j/2^LUT_BITS) * 2^QFRAC), j = 0..2^LUT_BITS.
// Contents are evaluated at elaboration, so no external memory image is needed.
module fx_exp2_rom
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH    = FP_WIDTH,
    parameter int QFRAC    = FP_QFRAC,
    parameter int LUT_BITS = FP_LUT_BITS
) (
    input  logic                i_clk,
    input  logic                i_en,
    input  logic [LUT_BITS:0]   i_addr_a,
    input  logic [LUT_BITS:0]   i_addr_b,
    output logic [WIDTH-1:0]    o_data_a,
    output logic [WIDTH-1:0]    o_data_b
);

    localparam int DEPTH = (1 << LUT_BITS) + 1;

    logic [WIDTH-1:0] w_tab [DEPTH];

    for (genvar j = 0; j < DEPTH; j++) begin : g_tab
        localparam real EXP2_VAL = 2.0 ** (real'(j) / real'(1 << LUT_BITS));
        localparam logic [WIDTH-1:0] ENTRY = WIDTH'($rtoi(EXP2_VAL * real'(1 << QFRAC) + 0.5));
        assign w_tab[j] = ENTRY;
    end

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            o_data_a <= w_tab[i_addr_a];
            o_data_b <= w_tab[i_addr_b];
        end
    end

endmodule

// File: rtl/fx_exp_lut.sv
// Four-stage exp(x) pipeline for Q16.16 x <= 0: x*log2e range reduction, 2^f table with
// linear interpolation, then a right shift by -k. A single stall freezes every stage.
module fx_exp_lut
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH    = FP_WIDTH,
    parameter int QFRAC    = FP_QFRAC,
    parameter int LUT_BITS = FP_LUT_BITS
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid_in,
    output logic               o_in_ready,
    input  logic [WIDTH-1:0]   i_x,
    output logic               o_valid_out,
    input  logic               i_out_ready,
    output logic [WIDTH-1:0]   o_exp_out,
    output logic               o_sat
);

    localparam int IB = QFRAC - LUT_BITS;
    localparam int KW = WIDTH - QFRAC;
    localparam logic [2*WIDTH-1:0] LOG2E_EXT = (2*WIDTH)'(FP_LOG2E);
    localparam logic signed [2*WIDTH-1:0] Y_MIN = -($signed((2*WIDTH)'(1)) <<< (QFRAC + 4));
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1) << QFRAC;

    logic                      r1_v, r2_v, r3_v, r4_v;
    logic [WIDTH-1:0]          r1_x;
    logic signed [2*WIDTH-1:0] w_y;
    logic                      w_pos, w_under;
    logic [LUT_BITS:0]         w_addr_a, w_addr_b;
    logic [WIDTH-1:0]          w_rom_a, w_rom_b;
    logic [KW-1:0]             r2_k, r3_k, w_negk;
    logic [IB-1:0]             r2_frac;
    exp_flags_t                r2_flags, r3_flags;
    logic [WIDTH-1:0]          w_m, r3_m;
    logic [WIDTH-1:0]          r_exp_out;
    logic                      r_sat;
    logic                      w_stall, w_adv;

    assign w_stall    = r4_v & ~i_out_ready;
    assign w_adv      = ~w_stall;
    assign o_in_ready = w_adv;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r1_v <= 1'b0;
        end else if (w_adv) begin
            r1_v <= i_valid_in;
            if (i_valid_in) r1_x <= i_x;
        end
    end

    // floor(x * log2e): arithmetic shift of the full-width signed product
    assign w_y      = ($signed({{WIDTH{r1_x[WIDTH-1]}}, r1_x}) * $signed(LOG2E_EXT)) >>> QFRAC;
    assign w_under  = (w_y < Y_MIN);
    assign w_pos    = ($signed(r1_x) > $signed(WIDTH'(0)));
    assign w_addr_a = {1'b0, w_y[QFRAC-1 -: LUT_BITS]};
    assign w_addr_b = w_addr_a + (LUT_BITS+1)'(1);

    fx_exp2_rom #(
        .WIDTH    (WIDTH),
        .QFRAC    (QFRAC),
        .LUT_BITS (LUT_BITS)
    ) u_rom (
        .i_clk    (i_clk),
        .i_en     (w_adv),
        .i_addr_a (w_addr_a),
        .i_addr_b (w_addr_b),
        .o_data_a (w_rom_a),
        .o_data_b (w_rom_b)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r2_v <= 1'b0;
        end else if (w_adv) begin
            r2_v <= r1_v;
            if (r1_v) begin
                r2_k           <= w_y[WIDTH-1:QFRAC];
                r2_frac        <= w_y[IB-1:0];
                r2_flags.pos   <= w_pos;
                r2_flags.under <= w_under;
            end
        end
    end

    // table is monotonic, so B - A never goes negative
    assign w_m = w_rom_a + (((w_rom_b - w_rom_a) * WIDTH'(r2_frac)) >> IB);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r3_v <= 1'b0;
        end else if (w_adv) begin
            r3_v <= r2_v;
            if (r2_v) begin
                r3_m     <= w_m;
                r3_k     <= r2_k;
                r3_flags <= r2_flags;
            end
        end
    end

    assign w_negk = KW'(0) - r3_k;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r4_v      <= 1'b0;
            r_exp_out <= '0;
            r_sat     <= 1'b0;
        end else if (w_adv) begin
            r4_v <= r3_v;
            if (r3_v) begin
                if (r3_flags.pos) begin
                    r_exp_out <= ONE_Q;
                    r_sat     <= 1'b1;
                end else if (r3_flags.under || (w_negk >= KW'(QFRAC + 1))) begin
                    r_exp_out <= '0;
                    r_sat     <= r3_flags.under;
                end else begin
                    r_exp_out <= r3_m >> w_negk;
                    r_sat     <= 1'b0;
                end
            end
        end
    end

    assign o_valid_out = r4_v;
    assign o_exp_out   = r_exp_out;
    assign o_sat       = r_sat;

endmodule

// File: tb/tb_fx_exp_lut.sv
// Bench for fx_exp_lut: real-valued exp model with an in-order scoreboard, plus directed literals.
module tb_fx_exp_lut;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        out_ready;
    logic [31:0] x;
    logic        in_ready;
    logic        valid_out;
    logic [31:0] exp_out;
    logic        sat;

    typedef struct {
        int x;
        int cyc;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    mode_ready = 0;
    int    n_out = 0;
    bit    lat_chk = 1'b0;

    fx_exp_lut dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid_in  (valid_in),
        .o_in_ready  (in_ready),
        .i_x         (x),
        .o_valid_out (valid_out),
        .i_out_ready (out_ready),
        .o_exp_out   (exp_out),
        .o_sat       (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // exp(x) from first principles; out-of-domain inputs are only tested far from the boundary
    task automatic model_check(input item_t it, input logic [31:0] v, input logic s);
        real e;
        int  ref_v;
        int  diff;
        if (it.x > 0) begin
            chk(v == 32'h00010000, "pos_value", v, 32'h00010000);
            chk(s == 1'b1, "pos_sat", s, 1);
        end else if (real'(it.x) / 65536.0 < -11.5) begin
            chk(v == 32'd0, "under_value", v, 0);
            chk(s == 1'b1, "under_sat", s, 1);
        end else begin
            e     = $exp(real'(it.x) / 65536.0) * 65536.0;
            ref_v = $rtoi(e + 0.5);
            diff  = int'(v) - ref_v;
            chk(diff >= -4 && diff <= 4, "exp_accuracy", v, ref_v);
            chk(s == 1'b0, "sat_clear", s, 0);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode_ready)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        bit          prev_stall = 1'b0;
        logic [31:0] prev_out = '0;
        logic        prev_sat = 1'b0;
        item_t       it;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            chk(in_ready == !(valid_out && !out_ready), "in_ready", in_ready, !(valid_out && !out_ready));
            if (prev_stall) begin
                chk(valid_out == 1'b1, "stall_valid_hold", valid_out, 1);
                chk(exp_out == prev_out, "stall_data_hold", exp_out, prev_out);
                chk(sat == prev_sat, "stall_sat_hold", sat, prev_sat);
            end
            if (valid_out && out_ready) begin
                if (q.size() == 0) begin
                    chk(1'b0, "spurious_output", exp_out, 0);
                end else begin
                    it = q.pop_front();
                    n_out++;
                    model_check(it, exp_out, sat);
                    if (lat_chk) chk(cyc - it.cyc == 4, "latency", cyc - it.cyc, 4);
                end
            end
            prev_stall = valid_out && !out_ready;
            prev_out   = exp_out;
            prev_sat   = sat;
        end
    end

    task automatic send(input logic [31:0] xv);
        bit done = 1'b0;
        valid_in = 1'b1;
        x = xv;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{x: $signed(xv), cyc: cyc});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        if (!done) chk(1'b0, "send_timeout", 0, 1);
    endtask

    task automatic wait_out(output logic [31:0] v, output logic s);
        bit got = 1'b0;
        v = '0;
        s = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (valid_out) begin
                v = exp_out;
                s = sat;
                got = 1'b1;
            end
        end
        if (!got) chk(1'b0, "wait_out_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        for (int t = 0; t < bound && q.size() != 0; t++) @(posedge clk);
        chk(q.size() == 0, "drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [31:0] v;
        logic        s;
        int          d;
        int          n0;

        rst = 1'b1;
        valid_in = 1'b0;
        x = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(valid_out == 1'b0, "reset_valid_out", valid_out, 0);
        chk(exp_out == 32'd0, "reset_exp_out", exp_out, 0);
        chk(sat == 1'b0, "reset_sat", sat, 0);
        chk(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        lat_chk = 1'b1;
        send(32'h00000000);
        wait_out(v, s);
        chk(v == 32'h00010000, "x0_value", v, 32'h00010000);
        chk(s == 1'b0, "x0_sat", s, 0);

        send(32'hFFFF4E8E);
        wait_out(v, s);
        d = int'(v) - 32'h8000;
        chk(d >= -2 && d <= 2, "neg_ln2_value", v, 32'h8000);

        send(32'hFFFF0000);
        wait_out(v, s);
        d = int'(v) - 24109;
        chk(d >= -4 && d <= 4, "neg_one_value", v, 24109);

        send(32'h00010000);
        wait_out(v, s);
        chk(v == 32'h00010000, "pos_one_value", v, 32'h00010000);
        chk(s == 1'b1, "pos_one_sat", s, 1);

        send(32'hFFF40000);
        wait_out(v, s);
        chk(v == 32'd0, "neg_twelve_value", v, 0);
        chk(s == 1'b1, "neg_twelve_sat", s, 1);
        lat_chk = 1'b0;

        for (int xi = -726784; xi <= 0; xi += 256) send(32'(xi));
        drain(100);

        n0 = n_out;
        mode_ready = 1;
        for (int k = 0; k < 16; k++) send(32'(-(k * 46000) - 123));
        mode_ready = 0;
        drain(500);
        chk(n_out - n0 == 16, "burst_count", n_out - n0, 16);

        send(32'hFFFF8000);
        send(32'hFFFE0000);
        send(32'hFFFC0000);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(valid_out == 1'b0, "midreset_valid_out", valid_out, 0);
        repeat (6) @(posedge clk);
        #1;
        n0 = n_out;
        lat_chk = 1'b1;
        send(32'hFFFD8000);
        repeat (10) @(posedge clk);
        #1;
        chk(n_out - n0 == 1, "post_reset_count", n_out - n0, 1);
        lat_chk = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
